// File: rtl/spi_word_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_xcvr
// Brief    : SPI mode-0 slave word transceiver, oversampled in the clk domain.
//            Receives command words and streams FWFT FIFO words onto MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_xcvr #(
  parameter int unsigned       WORD_W      = 16,
  parameter logic [WORD_W-1:0] IDLE_WORD   = '0,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              send_finish,
  output logic              frame_abort,
  input  logic              tx_active,
  input  logic [WORD_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx_underrun
);

  localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   armed_q, armed_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0]      rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   abort_q, abort_d;
  logic [WORD_W-1:0]      tx_shift_q, tx_shift_d;
  logic                   miso_q, oe_q;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_low;
  logic w_load;

  assign w_sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign w_cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign w_mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // CS sync resets low and armed_q only sets once CS is seen high, so a frame
  // already in progress when reset releases is ignored until a fresh cs_fall.
  assign w_sclk_rise = w_sclk_s & ~sclk_prev_q;
  assign w_sclk_fall = ~w_sclk_s & sclk_prev_q;
  assign w_cs_fall   = armed_q & cs_prev_q & ~w_cs_s;
  assign w_cs_rise   = armed_q & ~cs_prev_q & w_cs_s;
  assign w_cs_low    = armed_q & ~w_cs_s;
  assign armed_d     = armed_q | w_cs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= w_sclk_s;
      cs_prev_q   <= w_cs_s;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    tx_shift_d  = tx_shift_q;
    w_load      = 1'b0;
    fifo_rd_en  = 1'b0;
    tx_underrun = 1'b0;

    // cs_rise has priority so a colliding SCLK rise is never counted.
    if (w_cs_rise) begin
      bit_cnt_d = '0;
      abort_d   = (bit_cnt_q != 5'd0);
    end else if (w_cs_fall) begin
      bit_cnt_d = '0;
      w_load    = 1'b1;
    end else if (w_cs_low && w_sclk_rise) begin
      rx_shift_d = {rx_shift_q[WORD_W-3:0], w_mosi_s};
      if (bit_cnt_q == LAST_BIT) begin
        rx_data_d  = {rx_shift_q, w_mosi_s};
        rx_valid_d = 1'b1;
        bit_cnt_d  = '0;
        w_load     = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end else if (w_cs_low && w_sclk_fall && (bit_cnt_q != 5'd0)) begin
      tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
    end

    if (w_load) begin
      if (tx_active && !fifo_empty) begin
        tx_shift_d = fifo_rd_data;
        fifo_rd_en = 1'b1;
      end else begin
        tx_shift_d  = IDLE_WORD;
        tx_underrun = tx_active;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      tx_shift_q <= IDLE_WORD;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= tx_shift_q[WORD_W-1];
      oe_q       <= w_cs_low;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign send_finish = rx_valid_q;
  assign frame_abort = abort_q;

endmodule
`default_nettype wire
